// File: rtl/sram_pkg.sv
// Shared types and sizes for the 32-bit-over-16-bit SRAM controller.
package sram_pkg;
    localparam int SRAM_ADDR_W   = 18;
    localparam int SRAM_DATA_W   = 16;
    localparam int DEF_BASE_ADDR = 1024;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;
endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter timing each half-word phase; tc marks the last cycle of a phase.
module sram_wait_counter
    import sram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two timed 16-bit SRAM accesses (low half first)
// and freezes the pipeline via ready until the access completes.
module sram_controller
    import sram_pkg::*;
#(
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t                 state, state_nxt;
    op_t                    op;
    logic [SRAM_ADDR_W-2:0] word_idx;
    logic [31:0]            wdata;
    logic [SRAM_DATA_W-1:0] lo_half;
    logic [31:0]            offset;
    logic                   req, accept, cnt_load, cnt_en, tc, active, drive;
    logic                   unused_offset_bits;

    assign req                = wr_en | rd_en;
    assign offset             = address - 32'(BASE_ADDR);
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    sram_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (RELOAD),
        .tc       (tc)
    );

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        unique case (state)
            IDLE: begin
                ready = !req;
                if (req) begin
                    accept    = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = LO;
                end
            end
            LO: begin
                if (tc) begin
                    cnt_load  = 1'b1;
                    state_nxt = HI;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HI: begin
                if (tc) state_nxt = DONE;
                else    cnt_en    = 1'b1;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign active    = (state == LO) || (state == HI);
    assign drive     = active && (op == OP_WR);
    assign SRAM_WE_N = !drive;
    assign SRAM_OE_N = !(active && (op == OP_RD));
    assign SRAM_ADDR = active ? {word_idx, state == HI} : '0;
    assign SRAM_DQ   = drive ? ((state == HI) ? wdata[31:16] : wdata[15:0]) : 'z;

    // Low half is parked in lo_half so readData only changes once the whole word is in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op       <= OP_RD;
            word_idx <= '0;
            wdata    <= '0;
            lo_half  <= '0;
            readData <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op       <= wr_en ? OP_WR : OP_RD;
                word_idx <= offset[18:2];
                wdata    <= writeData;
            end
            if (state == LO && tc && op == OP_RD) lo_half  <= SRAM_DQ;
            if (state == HI && tc && op == OP_RD) readData <= {SRAM_DQ, lo_half};
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed table, hand-written corner sequences and
// random loads/stores checked against a half-word array model of the SRAM contents.
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst, preload;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        wr_a, rd_a, ready_a, we_a, oe_a;
    logic [31:0] addr_a, wd_a, rdata_a;
    logic [17:0] saddr_a;
    wire  [15:0] dq_a;
    logic        wr_b, rd_b, ready_b, we_b, oe_b;
    logic [31:0] addr_b, wd_b, rdata_b;
    logic [17:0] saddr_b;
    wire  [15:0] dq_b;

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .address(addr_a),
        .writeData(wd_a), .readData(rdata_a), .ready(ready_a), .SRAM_DQ(dq_a),
        .SRAM_ADDR(saddr_a), .SRAM_WE_N(we_a), .SRAM_OE_N(oe_a));

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .address(addr_b),
        .writeData(wd_b), .readData(rdata_b), .ready(ready_b), .SRAM_DQ(dq_b),
        .SRAM_ADDR(saddr_b), .SRAM_WE_N(we_b), .SRAM_OE_N(oe_b));

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 40503 + 12345);
    endfunction

    // SRAM devices; while the controller is not writing, the bench drives the bus
    // (read data, or an A5A5 probe) so a controller that fails to release it shows up.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    assign dq_a = we_a ? (oe_a ? 16'hA5A5 : mem_a[saddr_a[7:0]]) : 16'hzzzz;
    assign dq_b = we_b ? (oe_b ? 16'hA5A5 : mem_b[saddr_b[7:0]]) : 16'hzzzz;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_val(i);
                mem_b[i] <= init_val(i);
            end
        end else begin
            if (!we_a) mem_a[saddr_a[7:0]] <= dq_a;
            if (!we_b) mem_b[saddr_b[7:0]] <= dq_b;
        end
    end

    // Reference model: expected half-word contents and expected readData.
    logic [15:0] ref_a [256];
    logic [31:0] exp_rd_a;

    function automatic int widx(input logic [31:0] a);
        return int'((a - 32'd1024) >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One request held for the accept cycle only; counts freeze/strobe cycles up to DONE.
    task automatic run_a(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         output int low, output int wl, output int ol);
        @(negedge clk);
        wr_a = w; rd_a = r; addr_a = a; wd_a = d;
        low = 0; wl = 0; ol = 0;
        #1;
        while (!ready_a && low < 40) begin
            low++;
            if (!we_a) wl++;
            if (!oe_a) ol++;
            @(negedge clk);
            wr_a = 1'b0; rd_a = 1'b0; addr_a = $urandom; wd_a = $urandom;
            #1;
        end
    endtask

    task automatic txn_a(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input string tag);
        int low, wl, ol, k;
        k = widx(a);
        run_a(w, r, a, d, low, wl, ol);
        if (w) begin
            ref_a[2*k] = d[15:0]; ref_a[2*k+1] = d[31:16];
        end else if (r) begin
            exp_rd_a = {ref_a[2*k+1], ref_a[2*k]};
        end
        chk({tag, " ready_low"}, low, (w | r) ? 3 : 0);
        chk({tag, " we_low"}, wl, w ? 2 : 0);
        chk({tag, " oe_low"}, ol, (!w && r) ? 2 : 0);
        chk({tag, " readData"}, rdata_a, exp_rd_a);
        if (w) chk({tag, " sram"}, {mem_a[2*k+1], mem_a[2*k]}, {ref_a[2*k+1], ref_a[2*k]});
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        int          exp_low;
    } vec_t;

    vec_t        tbl [8];
    int          low, wl, ol, k, sel;
    logic [15:0] bits;
    logic [31:0] e1, e2, ra;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; preload = 1'b1;
        wr_a = 0; rd_a = 0; addr_a = 0; wd_a = 0;
        wr_b = 0; rd_b = 0; addr_b = 0; wd_b = 0;
        for (int i = 0; i < 256; i++) ref_a[i] = init_val(i);
        exp_rd_a = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0; preload = 1'b0;
        #1;
        chk("reset ready", ready_a, 1);
        chk("reset readData", rdata_a, 0);
        chk("reset we_n", we_a, 1);
        chk("reset oe_n", oe_a, 1);
        chk("reset addr", saddr_a, 0);
        chk("reset dq released", dq_a, 16'hA5A5);
        chk("reset ready w3", ready_b, 1);

        // Write 0xDEADBEEF to 1028, cycle by cycle.
        @(negedge clk);
        wr_a = 1; addr_a = 32'd1028; wd_a = 32'hDEADBEEF; #1;
        chk("wr idle ready", ready_a, 0);
        chk("wr idle addr", saddr_a, 0);
        @(negedge clk);
        wr_a = 0; addr_a = 0; wd_a = 0; #1;
        chk("wr lo addr", saddr_a, 2);
        chk("wr lo dq", dq_a, 16'hBEEF);
        chk("wr lo we_n", we_a, 0);
        chk("wr lo oe_n", oe_a, 1);
        chk("wr lo ready", ready_a, 0);
        @(negedge clk); #1;
        chk("wr hi addr", saddr_a, 3);
        chk("wr hi dq", dq_a, 16'hDEAD);
        chk("wr hi we_n", we_a, 0);
        chk("wr hi ready", ready_a, 0);
        @(negedge clk); #1;
        chk("wr done ready", ready_a, 1);
        chk("wr done we_n", we_a, 1);
        chk("wr done addr", saddr_a, 0);
        chk("wr done dq released", dq_a, 16'hA5A5);
        ref_a[2] = 16'hBEEF; ref_a[3] = 16'hDEAD;

        // WAIT_CYCLES=3: back-to-back reads with rd_en held, address changed mid-access.
        e1 = {init_val(3), init_val(2)};
        e2 = {init_val(11), init_val(10)};
        @(negedge clk);
        rd_b = 1; addr_b = 32'd1028; ol = 0; bits = '0;
        for (int i = 0; i < 16; i++) begin
            #1;
            bits[i] = ready_b;
            if (!oe_b) ol++;
            if (i == 1)  chk("b2b first lo addr", saddr_b, 2);
            if (i == 4)  chk("b2b first hi addr", saddr_b, 3);
            if (i == 7)  chk("b2b first data", rdata_b, e1);
            if (i == 9)  chk("b2b second lo addr", saddr_b, 10);
            if (i == 12) chk("b2b second hi addr", saddr_b, 11);
            if (i == 15) chk("b2b second data", rdata_b, e2);
            if (i == 2)  addr_b = 32'd1044;
            if (i == 15) rd_b = 0;
            @(negedge clk);
        end
        #1;
        chk("b2b ready pattern", bits, 16'h8080);
        chk("b2b oe_low cycles", ol, 12);
        chk("b2b no third access", {ready_b, oe_b}, 2'b11);

        // WAIT_CYCLES=3 write.
        @(negedge clk);
        wr_b = 1; addr_b = 32'd1024; wd_b = 32'h600DCAFE; low = 0; wl = 0; #1;
        while (!ready_b && low < 40) begin
            low++;
            if (!we_b) wl++;
            @(negedge clk);
            wr_b = 0; #1;
        end
        chk("w3 ready_low", low, 7);
        chk("w3 we_low", wl, 6);
        chk("w3 sram", {mem_b[1], mem_b[0]}, 32'h600DCAFE);
        chk("w3 readData hold", rdata_b, e2);

        // Directed table on the WAIT_CYCLES=1 instance.
        tbl[0] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hDEADBEEF, 3};
        tbl[1] = '{1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 3};
        tbl[2] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'h12345678, 3};
        tbl[3] = '{1'b0, 1'b0, 32'd1036, 32'hFFFFFFFF, 32'h12345678, 0};
        tbl[4] = '{1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 32'h12345678, 3};
        tbl[5] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hCAFEF00D, 3};
        tbl[6] = '{1'b1, 1'b0, 32'd1276, 32'h0A0B0C0D, 32'hCAFEF00D, 3};
        tbl[7] = '{1'b0, 1'b1, 32'd1276, 32'h0,        32'h0A0B0C0D, 3};
        foreach (tbl[i]) begin
            run_a(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, low, wl, ol);
            chk($sformatf("tbl%0d ready_low", i), low, tbl[i].exp_low);
            chk($sformatf("tbl%0d readData", i), rdata_a, tbl[i].exp_rd);
            if (tbl[i].w) begin
                k = widx(tbl[i].a);
                ref_a[2*k] = tbl[i].d[15:0]; ref_a[2*k+1] = tbl[i].d[31:16];
            end
            exp_rd_a = tbl[i].exp_rd;
        end

        // Reset in the HI phase of a read aborts it and clears readData.
        @(negedge clk);
        rd_a = 1; addr_a = 32'd1028; #1;
        @(negedge clk);
        rd_a = 0; #1;
        chk("abort lo oe_n", oe_a, 0);
        @(negedge clk); #1;
        chk("abort hi addr", saddr_a, 3);
        rst = 1;
        @(negedge clk);
        rst = 0; #1;
        chk("abort ready", ready_a, 1);
        chk("abort we_n/oe_n", {we_a, oe_a}, 2'b11);
        chk("abort addr", saddr_a, 0);
        chk("abort dq released", dq_a, 16'hA5A5);
        chk("abort readData", rdata_a, 0);
        exp_rd_a = 32'h0;
        txn_a(1'b0, 1'b1, 32'd1028, 32'h0, "after abort");

        // Random loads/stores/both/idle against the model.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            ra  = 32'd1024 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            txn_a(sel == 0 || sel == 2, sel == 1 || sel == 2, ra, $urandom, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter BASE_ADDR, default 1024, data-memory base byte address subtracted from the ALU address.
REQ-002 Parameter WAIT_CYCLES, default 1, clock cycles per 16-bit SRAM access (legal range 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  memory write request (MEM_W_EN from EXE/MEM register).
REQ-006 rd_en  input  1  memory read request (MEM_R_EN from EXE/MEM register).
REQ-007 address  input  32  byte address (ALU_Res from EXE/MEM register).
REQ-008 writeData  input  32  store value (ST_Val from EXE/MEM register).
REQ-009 readData  output  32  load result, registered.
REQ-010 ready  output  1  high = memory stage may advance; low = pipeline freeze.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM half-word address.
REQ-013 SRAM_WE_N  output  1  SRAM write enable, active low.
REQ-014 SRAM_OE_N  output  1  SRAM output enable, active low.

Function
REQ-015 FSM states: IDLE, LO, HI, DONE.
REQ-016 IDLE with wr_en|rd_en: ready=0 combinationally that cycle; latch op, word index (address-BASE_ADDR)[18:2], writeData; next state LO.
REQ-017 IDLE with no request: ready=1, stay IDLE.
REQ-018 wr_en and rd_en both high: write SHALL take priority; no read performed.
REQ-019 LO lasts exactly WAIT_CYCLES cycles, SRAM_ADDR={word index,1'b0}; then HI.
REQ-020 HI lasts exactly WAIT_CYCLES cycles, SRAM_ADDR={word index,1'b1}; then DONE.
REQ-021 DONE lasts one cycle, ready=1; next state IDLE unconditionally (DONE never starts a new access).
REQ-022 Ready low 2*WAIT_CYCLES+1 consecutive cycles per request, high in the DONE cycle.
REQ-023 Write: SRAM_DQ driven with writeData[15:0] in LO, [31:16] in HI; SRAM_WE_N=0 in LO and HI; SRAM_OE_N=1.
REQ-024 Read: SRAM_DQ high-Z; SRAM_OE_N=0 in LO and HI; SRAM_WE_N=1.
REQ-025 Read: readData[15:0] captured from SRAM_DQ on final LO cycle edge, readData[31:16] on final HI cycle edge.
REQ-026 readData SHALL hold its value through writes and idle until the next read completes.
REQ-027 Outside LO/HI: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z, SRAM_ADDR=0.
REQ-028 Request inputs changing after IDLE acceptance SHALL NOT affect the access in progress.
REQ-029 Wait counter 4 bits, reloaded on each LO/HI entry, no wrap beyond WAIT_CYCLES-1.

Reset
REQ-030 rst SHALL force IDLE, counter 0, readData 0, latched op/address/data 0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z; ready=1 after the reset cycle.
REQ-031 rst during LO/HI SHALL abort the access same edge; no partial readData update.

Structure
REQ-032 Shared package sram_pkg holds state enum, SRAM_ADDR_W=18, SRAM_DATA_W=16, default BASE_ADDR.
REQ-033 One sub-module sram_wait_counter: load/decrement, terminal-count flag.

Verification
REQ-034 Write 0xDEADBEEF to address 1028, WAIT_CYCLES=1 -> SRAM_ADDR 2 with DQ 0xBEEF, then SRAM_ADDR 3 with DQ 0xDEAD, WE_N low 2 cycles, ready low 3 cycles.
REQ-035 Read address 1028 with SRAM model holding 0xBEEF/0xDEAD -> readData=0xDEADBEEF in DONE cycle, ready high exactly one cycle.
REQ-036 WAIT_CYCLES=3, back-to-back reads held on rd_en -> ready low 7 cycles, high 1, low 7; two distinct accesses, no duplicate.
REQ-037 wr_en and rd_en both high, address 1032, data 0x12345678 -> write performed, readData unchanged.
REQ-038 rst asserted in HI of a read -> next cycle IDLE, WE_N=OE_N=1, DQ high-Z, readData=0.
REQ-039 rd_en deasserted during LO -> access completes, readData updated, ready returns high.
